// File: rtl/hw_accel_scale_pack_if.sv
// hw_accel_scale_pack_if: pixel stream into the scaler/packer and packed word stream out
interface hw_accel_scale_pack_if;
  logic [1:0]  pack_mode;
  logic [23:0] pixel_in;
  logic        pixel_in_valid;
  logic        pixel_in_sof;
  logic [31:0] pixel_out;
  logic        pixel_out_valid;
  logic        frame_done;
  logic        sync_err;
  modport master (
    output pack_mode, pixel_in, pixel_in_valid, pixel_in_sof,
    input  pixel_out, pixel_out_valid, frame_done, sync_err
  );
  modport slave (
    input  pack_mode, pixel_in, pixel_in_valid, pixel_in_sof,
    output pixel_out, pixel_out_valid, frame_done, sync_err
  );
endinterface

// File: rtl/hw_accel_scale_pack.sv
// hw_accel_scale_pack: nearest-neighbour downscaler fused with an RGB/BGR/gray byte packer
module hw_accel_scale_pack #(
  parameter int IN_FRAME_WIDTH   = 540,
  parameter int IN_FRAME_HEIGHT  = 540,
  parameter int OUT_FRAME_WIDTH  = 96,
  parameter int OUT_FRAME_HEIGHT = 96
) (
  input logic clk,
  input logic rst,
  hw_accel_scale_pack_if.slave s
);
  localparam int XW = $clog2(IN_FRAME_WIDTH + 1) + 1;
  localparam int YW = $clog2(IN_FRAME_HEIGHT + 1) + 1;
  localparam logic [XW-1:0] QX = XW'(IN_FRAME_WIDTH / OUT_FRAME_WIDTH);
  localparam logic [XW-1:0] RX = XW'(IN_FRAME_WIDTH % OUT_FRAME_WIDTH);
  localparam logic [XW-1:0] OX = XW'(OUT_FRAME_WIDTH);
  localparam logic [XW-1:0] LX = XW'(IN_FRAME_WIDTH - 1);
  localparam logic [YW-1:0] QY = YW'(IN_FRAME_HEIGHT / OUT_FRAME_HEIGHT);
  localparam logic [YW-1:0] RY = YW'(IN_FRAME_HEIGHT % OUT_FRAME_HEIGHT);
  localparam logic [YW-1:0] OY = YW'(OUT_FRAME_HEIGHT);
  localparam logic [YW-1:0] LY = YW'(IN_FRAME_HEIGHT - 1);
  logic [XW-1:0] x, nx, rx, ex, enx, erx, sx;
  logic [YW-1:0] y, ny, ry, ey, eny, ery, sy;
  logic          restart, first, col_sel, row_sel, eol, eof, keep;
  logic [1:0]    mode_q, mode;
  logic [15:0]   gsum;
  logic [7:0]    gray;
  logic [23:0]   bytes;
  logic [23:0]   s1_bytes;
  logic [1:0]    s1_n;
  logic          s1_last, s1_restart;
  logic [23:0]   res, res_b;
  logic [1:0]    cnt, cnt_b;
  logic          fl_pend, clr;
  logic [2:0]    total;
  logic [47:0]   acc;
  // a mid-frame SOF makes this pixel (0,0): all position state is viewed as freshly cleared
  always_comb begin
    restart = s.pixel_in_valid & s.pixel_in_sof & (x != '0 | y != '0);
    ex = restart ? '0 : x;
    enx = restart ? '0 : nx;
    erx = restart ? '0 : rx;
    ey = restart ? '0 : y;
    eny = restart ? '0 : ny;
    ery = restart ? '0 : ry;
    first = ex == '0 && ey == '0;
    col_sel = ex == enx;
    row_sel = ey == eny;
    eol = ex == LX;
    eof = eol && ey == LY;
    keep = s.pixel_in_valid & col_sel & row_sel;
    mode = first ? s.pack_mode : mode_q;
    sx = erx + RX;
    sy = ery + RY;
    gsum = 16'd77 * {8'd0, s.pixel_in[23:16]} + 16'd150 * {8'd0, s.pixel_in[15:8]} + 16'd29 * {8'd0, s.pixel_in[7:0]};
    gray = 8'(gsum >> 8);
    bytes = mode == 2'd1 ? s.pixel_in :
            mode == 2'd2 ? {16'd0, gray} :
            {s.pixel_in[7:0], s.pixel_in[15:8], s.pixel_in[23:16]};
  end
  // nx/ny hold the next selected column/row as floor(j*IN/OUT), stepped by quotient plus carried remainder
  always_ff @(posedge clk)
    if (rst) begin
      x <= '0;
      nx <= '0;
      rx <= '0;
      y <= '0;
      ny <= '0;
      ry <= '0;
      mode_q <= 2'd0;
    end else if (s.pixel_in_valid) begin
      x <= eol ? '0 : ex + XW'(1);
      nx <= eol ? '0 : col_sel ? enx + QX + XW'(sx >= OX) : enx;
      rx <= eol ? '0 : col_sel ? (sx >= OX ? sx - OX : sx) : erx;
      y <= eof ? '0 : eol ? ey + YW'(1) : ey;
      ny <= eof ? '0 : eol && row_sel ? eny + QY + YW'(sy >= OY) : eny;
      ry <= eof ? '0 : eol && row_sel ? (sy >= OY ? sy - OY : sy) : ery;
      if (first) mode_q <= s.pack_mode;
    end
  always_ff @(posedge clk)
    if (rst) begin
      s1_bytes <= '0;
      s1_n <= 2'd0;
      s1_last <= 1'b0;
      s1_restart <= 1'b0;
      s.sync_err <= 1'b0;
    end else begin
      s1_bytes <= keep ? bytes : '0;
      s1_n <= keep ? (mode == 2'd2 ? 2'd1 : 2'd3) : 2'd0;
      s1_last <= s.pixel_in_valid & eof;
      s1_restart <= restart;
      s.sync_err <= restart;
    end
  // a flush cycle hands its residual to the output, so a next-frame pixel starts from empty
  always_comb begin
    clr = fl_pend | s1_restart;
    cnt_b = clr ? 2'd0 : cnt;
    res_b = clr ? 24'd0 : res;
    total = {1'b0, cnt_b} + {1'b0, s1_n};
    acc = {24'd0, res_b} | ({24'd0, s1_bytes} << {cnt_b, 3'b000});
  end
  always_ff @(posedge clk)
    if (rst) begin
      res <= '0;
      cnt <= 2'd0;
      fl_pend <= 1'b0;
      s.frame_done <= 1'b0;
      s.pixel_out_valid <= 1'b0;
      s.pixel_out <= '0;
    end else begin
      res <= total[2] ? {8'd0, acc[47:32]} : acc[23:0];
      cnt <= total[1:0];
      fl_pend <= s1_last;
      s.frame_done <= fl_pend;
      s.pixel_out_valid <= fl_pend ? cnt != 2'd0 : total[2];
      s.pixel_out <= fl_pend ? {8'd0, res} : acc[31:0];
    end
endmodule

// File: doc/hw_accel_scale_pack.md
# hw_accel_scale_pack

Streaming nearest-neighbour downscaler fused with a runtime-selectable byte packer (RGB, BGR or grayscale) that emits 32-bit words for the DMA write path of the hardware accelerator. It replaces the fixed 96×96/RGB-only scale-then-pack chain with parametrised input and output geometry and a per-frame pack mode. It adds luma conversion, frame resynchronisation, end-of-frame flush of partial words and a frame-done pulse.

## Interface
- IN_FRAME_WIDTH, 540, input columns per line
- IN_FRAME_HEIGHT, 540, input lines per frame
- OUT_FRAME_WIDTH, 96, output columns; must be ≥1 and ≤ IN_FRAME_WIDTH
- OUT_FRAME_HEIGHT, 96, output lines; must be ≥1 and ≤ IN_FRAME_HEIGHT
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- pack_mode  in  2  0 = R→G→B, 1 = B→G→R, 2 = grayscale, 3 = treated as 0
- pixel_in  in  24  R[23:16], G[15:8], B[7:0]
- pixel_in_valid  in  1  pixel qualifier; no backpressure
- pixel_in_sof  in  1  qualified by valid; marks pixel (0,0) of a frame
- pixel_out  out  32  packed word; first byte of the stream in [7:0]
- pixel_out_valid  out  1  one-cycle word strobe
- frame_done  out  1  one-cycle pulse per completed frame
- sync_err  out  1  one-cycle pulse on SOF arriving mid-frame

## Operation
- Input position counters x (0..IN_W-1) and y (0..IN_H-1) advance on each valid pixel. x wraps to 0 and increments y. After (IN_W-1, IN_H-1), both wrap to (0,0). Frames chain without SOF.
- Column x is selected iff x == floor(j·IN_W/OUT_W) for some j in 0..OUT_W-1. Rows use the same rule with H. A pixel is kept iff both its column and its row are selected. Tracking uses integer+remainder step registers; no divider.
- pack_mode is latched on the first valid pixel of each frame (counters at (0,0)). Changes mid-frame have no effect.
- Per kept pixel, the byte stream is as follows:
  - mode 0: R, G, B
  - mode 1: B, G, R
  - mode 2: one byte, gray = (77·R + 150·G + 29·B) >> 8, using a 16-bit sum with no rounding.
- The packer holds 0–3 residual bytes. When the residual plus new bytes reach ≥4, it emits one word and keeps the remainder. At most one word is produced per input pixel.
- End of frame (last input pixel accepted):
  - If the residual is nonzero, one flush word is emitted with the residual in the low bytes and upper bytes zero. The residual is then cleared.
  - frame_done pulses.
- SOF with valid while counters ≠ (0,0):
  - sync_err pulses.
  - The residual is discarded with no flush and no frame_done.
  - Counters reset so that this pixel is (0,0).
  - pack_mode is re-latched.
- SOF at (0,0) is a no-op beyond the normal behaviour.
- Reset:
  - All outputs are 0.
  - Counters, residual, latched mode (=0) and pipeline valids are cleared.
  - In-flight words are dropped.

## Timing
- Stage 1 registers the select decision, the formatted bytes and gray. Stage 2 registers the packed word.
- A word completed by the pixel accepted in cycle N has pixel_out_valid in cycle N+2.
- A flush word and frame_done occur in cycle L+3, where L is the cycle of the last pixel. This is one cycle later than a regular word from pixel L, so they never collide.
- sync_err occurs in cycle N+1 after the offending SOF. A discarded residual never appears on pixel_out.
- Rst asserted in cycle N means all outputs are 0 from N+1. The first pixel after deassertion is (0,0).
- Throughput is one pixel per cycle sustained. Gaps in valid are allowed anywhere.

## Test plan
- Defaults, mode 0, continuous 540×540 frame with R=x[7:0], G=y[7:0], B=0x5A → exactly 6912 words and no flush.
  - First word is 0x05_5A_00_00: bytes R0=0, G0=0, B0=0x5A, then R1=5 from column 5.
  - frame_done occurs once, at L+3.
- Defaults, mode 2, all pixels (255,255,255) → 2304 words of 0xFFFFFFFF. Pixel (0,0,0) → 0x00000000.
- IN 10×4, OUT 3×2, mode 0 → kept columns 0, 3, 6 and rows 0, 2, giving 18 bytes.
  - 4 regular words, then a flush word 0x0000_BBGG holding the last pixel's G and B, together with frame_done at L+3.
- Mode 1 versus mode 0 on the same frame → bytes reversed per pixel.
  - Toggling pack_mode mid-frame leaves the output unchanged until the next frame.
- SOF injected at (3,1) of a 10×4 frame → sync_err pulses once and the partial residual is not emitted.
  - The following frame produces the exact 10×4 golden output.
- Rst pulsed mid-frame with words in flight → pixel_out_valid is 0 from the next cycle and no stale word appears.
  - A clean frame afterwards matches golden, with frame_done once.
